// File: rtl/cpu_trace_buffer_if.sv
// CPU trace bus and read-port bundle for cpu_trace_buffer.
// The CPU side drives fetch/opcode/addresses/data/halt; the consumer pops through rd_*.
interface cpu_trace_buffer_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  localparam int ENTRY_W = 2 * ADDR_W + OP_W + DATA_W;

  logic                fetch;
  logic [OP_W-1:0]     opcode;
  logic [ADDR_W-1:0]   pc_addr;
  logic [ADDR_W-1:0]   ir_addr;
  logic [DATA_W-1:0]   data;
  logic                halt;
  logic                rd_req;
  logic                rd_valid;
  logic [ENTRY_W-1:0]  rd_entry;

  modport master (
    output fetch, opcode, pc_addr, ir_addr, data, halt, rd_req,
    input  rd_valid, rd_entry
  );

  modport slave (
    input  fetch, opcode, pc_addr, ir_addr, data, halt, rd_req,
    output rd_valid, rd_entry
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Trace capture buffer: records {pc, opcode, ir_addr, data} on each fetch rising edge
// while capturing, with optional opcode trigger, halt stop and stop-or-wrap when full.
module cpu_trace_buffer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig_en,
  input  logic [OP_W-1:0]        trig_op,
  cpu_trace_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic                   halted
);
  localparam int PW      = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * ADDR_W + OP_W + DATA_W;
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);
  localparam bit STOP_ON_FULL = (WRAP == 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] STOPPED = 2'd3;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               fetch_q;
  logic               halt_q;

  logic ev, halt_edge, pop, trig_hit, do_write, drop, wr_en, rd_adv, inc, clear;

  // NOTE: every signal of an always_comb block is assigned on every path, so no latch can form.
  always_comb begin
    ev        = bus.fetch & ~fetch_q;
    halt_edge = bus.halt & ~halt_q;
    pop       = bus.rd_req & ~empty;
    trig_hit  = ev & (bus.opcode == trig_op);
    do_write  = ~abort & (((state == CAPTURE) & ev) | ((state == ARMED) & trig_hit));
    // A pop in the same cycle frees the slot, so a full buffer only drops when nothing is read.
    drop      = full & ~pop & STOP_ON_FULL;
    wr_en     = do_write & ~drop;
    rd_adv    = pop | (wr_en & full);
    inc       = wr_en & (~full | pop);
    clear     = ~abort & (state == STOPPED) & arm;
  end

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign bus.rd_valid = ~empty;
  assign bus.rd_entry = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define which slots are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.pc_addr, bus.opcode, bus.ir_addr, bus.data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      halted   <= 1'b0;
      fetch_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      fetch_q <= bus.fetch;
      halt_q  <= bus.halt;

      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        halted   <= 1'b0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
        if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW + 1)'(inc) - (PW + 1)'(pop);
        if (do_write & full & ~pop) overflow <= 1'b1;
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, STOPPED: if (arm) state <= trig_en ? ARMED : CAPTURE;
          ARMED:         if (trig_hit) state <= drop ? STOPPED : CAPTURE;
          CAPTURE: begin
            if (halt_edge | (ev & drop)) state <= STOPPED;
            if (halt_edge) halted <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameters:
- ADDR_W, 13, CPU address width.
- DATA_W, 8, data bus width.
- OP_W, 3, opcode width.
- DEPTH, 16, entries; power of two, at least 2.
- WRAP, 0: 0 = stop capturing when full; 1 = circular, overwrite the oldest entry.

REQ-002 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; starts a capture session.
- abort  in  1  one-cycle pulse; ends the session.
- trig_en  in  1  1 = wait for the trigger opcode before capturing.
- trig_op  in  OP_W  trigger opcode.
- fetch  in  1  CPU fetch phase.
- opcode  in  OP_W  CPU opcode.
- pc_addr  in  ADDR_W  CPU PC.
- ir_addr  in  ADDR_W  CPU operand address.
- data  in  DATA_W  CPU data bus value.
- halt  in  1  CPU halt.
- rd_req  in  1  pop request.
- rd_valid  out  1  rd_entry is valid.
- rd_entry  out  2*ADDR_W+OP_W+DATA_W  entry {pc, opcode, ir_addr, data}, oldest first.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; an event was dropped or overwritten.
- state  out  2  FSM state encoding.
- halted  out  1  sticky; the session stopped on halt.

Function
REQ-003 FSM states and encodings: IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.

REQ-004 Transitions:
- IDLE --arm--> ARMED when trig_en=1.
- IDLE --arm--> CAPTURE when trig_en=0.
- ARMED --event with opcode==trig_op--> CAPTURE; the triggering event is stored.
- CAPTURE --halt rising edge--> STOPPED; sets halted.
- CAPTURE --full with WRAP=0 and a further event--> STOPPED.
- Any state --abort--> IDLE; stored entries are kept.
- STOPPED --arm--> ARMED or CAPTURE; clears the buffer, overflow and halted.

REQ-005 Event definition:
- An event is a rising edge of fetch, detected from the fetch input registered on clk.
- At most one event per cycle.

REQ-006 Capture timing:
- In CAPTURE, an event writes {pc_addr, opcode, ir_addr, data}, sampled in the event cycle, into the write pointer slot.
- The entry is visible through count exactly one cycle later.

REQ-007 Events in IDLE or STOPPED are ignored and do not set overflow.

REQ-008 Full behaviour:
- WRAP=0: an event while full is dropped, sets overflow, and causes the STOPPED transition.
- WRAP=1: an event while full overwrites the oldest entry, advances both pointers, sets overflow, and leaves count at DEPTH.

REQ-009 Read port:
- rd_valid = !empty (combinational).
- rd_entry = entry at the read pointer.
- rd_req while rd_valid pops one entry at the clock edge.
- rd_req while empty is ignored.
- Reads are allowed in every state.

REQ-010 Simultaneous write and pop while not full: both occur and count is unchanged.

REQ-011 Simultaneous write and pop while full:
- The pop occurs first, then the write; count stays DEPTH.
- overflow is not set.
- The FSM does not enter STOPPED.

REQ-012 Pointers:
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is tracked separately so that full and empty are unambiguous.

REQ-013 Priority within a cycle: abort > halt edge > event > arm.

REQ-014 A halt rising edge in the same cycle as an event: the event is stored first, then the FSM enters STOPPED.

REQ-015 Only a rising edge of halt causes STOPPED; a halt level held from before arm does not.

Reset
REQ-016 When reset_n=0, asynchronously:
- state=IDLE.
- Pointers=0, count=0, empty=1, full=0.
- overflow=0, halted=0, rd_valid=0.
- Registered fetch and halt=0.

REQ-017 Buffer storage contents are not reset; rd_entry is don't-care while empty.

REQ-018 Reset asserted mid-session aborts capture; the first event after release is ignored until arm.

Verification
REQ-019 DEPTH=4, WRAP=0, trig_en=0: arm, then 3 fetch edges with pc=0x000/0x002/0x004 -> count=3; pops return pc 0x000, 0x002, 0x004 in order; empty=1 afterwards.

REQ-020 DEPTH=4, WRAP=0: 6 events -> count=4, full=1, overflow=1, state=STOPPED; the entries hold events 1-4.

REQ-021 DEPTH=4, WRAP=1: 6 events, pc=0x00..0x0A step 2 -> count=4, overflow=1, state=CAPTURE; pops return pc 0x04, 0x06, 0x08, 0x0A.

REQ-022 trig_en=1, trig_op=3'b111 (JMP): events with opcodes 101, 110, 111, 010 -> only the 111 and 010 events are stored; count=2.

REQ-023 Full with WRAP=0: event coincident with rd_req -> count stays 4, overflow=0, the new entry is at the tail; then a halt edge -> STOPPED, halted=1.

REQ-024 reset_n pulled low for 30 ns mid-CAPTURE, away from any clk edge -> immediately count=0, state=IDLE; subsequent fetch edges are not stored.
